hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the execute stage.
- Keeps a register scoreboard of in-flight writes between issue into execute and write-back. Stalls decode on RAW hazards.
- On a taken branch reported by execute, sequences a fixed-length flush of the front end.
- Sits beside decode/execute; drives decode's stall and fetch/decode flush.

Parameters:
- FLUSH_DEPTH, 2, number of cycles flush_o stays high after a taken branch (front-end stages to drain); legal range 1..7.
- CNT_W, 2, width of each per-register pending-write counter; supports up to 2^CNT_W-1 in-flight writes to one register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- issue_valid_i  in  1  decode output valid toward execute.
- issue_ready_i  in  1  execute input ready; an issue is issue_valid_i & issue_ready_i & ~stall_o & ~flush_o & ~branch_i.
- issue_reg_write_i  in  1  issued instruction writes a register.
- issue_reg_addr_i  in  5  issued destination register.
- dec_rs1_addr_i  in  5  decode source register 1.
- dec_rs1_used_i  in  1  rs1 is read.
- dec_rs2_addr_i  in  5  decode source register 2.
- dec_rs2_used_i  in  1  rs2 is read.
- wb_write_i  in  1  write-back commits a register this cycle.
- wb_addr_i  in  5  write-back destination.
- branch_i  in  1  registered taken-branch flag from execute.
- stall_o  out  1  decode must hold its instruction.
- flush_o  out  1  fetch/decode must discard contents.
- kill_o  out  1  combinational; execute must treat the current input as invalid.
- sb_overflow_o  out  1  sticky; a counter increment was attempted at saturation.

Behaviour:
- Reset (async, rst_i=1): all counters 0, FSM IDLE, flush count 0, sb_overflow_o 0. stall_o=0 and flush_o=0 while reset is held.
- Scoreboard: one CNT_W counter per register x1..x31. x0 is never pending and its writes are ignored.
  - Increment on qualified issue with issue_reg_write_i=1.
  - Decrement on wb_write_i=1.
  - Increment and decrement of the same register in the same cycle: no change.
  - Increment at max: hold at max and set sb_overflow_o.
  - Decrement at 0: ignored.
- stall_o is combinational from registered state: (rs1_used & pending[rs1]) | (rs2_used & pending[rs2]).
  - pending[r] means counter != 0.
  - A write-back in the same cycle does not clear the stall; the stall releases the following cycle (no bypass).
- kill_o = branch_i. The instruction presented to execute in the branch cycle is wrong-path; it is not counted in the scoreboard.
- Flush FSM:
  - IDLE: when branch_i=1, go to FLUSH with count=FLUSH_DEPTH-1.
  - FLUSH: flush_o=1 and issue is blocked. Decrement count each cycle; at count=0 return to IDLE.
  - branch_i=1 while in FLUSH reloads count to FLUSH_DEPTH-1.
- Latency: branch_i at cycle N gives flush_o high for cycles N+1..N+FLUSH_DEPTH.
- Write-backs continue to decrement counters during FLUSH; in-flight older instructions are valid.
- stall_o is still computed during FLUSH but has no effect on issue.
- Reset mid-flush or with writes pending: everything clears immediately.

Optional Feature:
- Macro ECAP5_DPROC_HAZARD_PERF_EN.
- When defined: adds outputs perf_stall_cycles_o[31:0] and perf_flush_cycles_o[31:0].
  - Each counts cycles with stall_o & issue_valid_i & ~flush_o, and flush_o, respectively.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- ecap5_dproc_pkg gains:
  - typedef enum logic {HAZARD_IDLE, HAZARD_FLUSH} hazard_state_t.
  - REG_COUNT=32.
- Sub-module hazard_scoreboard (counters, inc/dec, pending vector, overflow).
- The top level holds the FSM, qualification logic and perf counters.

Test Plan:
- Issue x5 write, next cycle decode reads rs1=x5 → stall_o=1 until the cycle after wb_write_i with addr 5. Then stall_o=0.
- Issue x0 write, then decode reads x0 → stall_o never asserts; counter for x0 is not modified.
- branch_i pulse at cycle 10 with FLUSH_DEPTH=2 → kill_o=1 at 10, flush_o=1 at 11–12, 0 at 13. Issue at cycle 10 of an x7 write leaves pending[7]=0.
- branch_i at cycle 10 and again at 11 → flush_o high for 11–13.
- Three issues to x3 with no write-back and CNT_W=2 → counter reaches 3. A fourth issue sets sb_overflow_o=1 and the counter stays 3. Three write-backs clear stall on x3.
- Assert rst_i asynchronously mid-flush with x4 pending → flush_o, stall_o, sb_overflow_o and (under ECAP5_DPROC_HAZARD_PERF_EN) perf counters read 0 before the next clock edge.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package ecap5_dproc_pkg;

  // Flush sequencer states.
  typedef enum logic {HAZARD_IDLE, HAZARD_FLUSH} hazard_state_t;

  // Architectural register file size and address width.
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: one pending-write counter per register x1..x31.
// x0 has no counter, so it is never pending and increments/decrements to it are dropped.
// overflow_o is sticky and records an increment attempted while a counter was saturated.
module hazard_scoreboard
  import ecap5_dproc_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_en_i,
  input  logic [REG_ADDR_W-1:0] inc_addr_i,
  input  logic                  dec_en_i,
  input  logic [REG_ADDR_W-1:0] dec_addr_i,
  output logic [REG_COUNT-1:0]  pending_o,
  output logic                  overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [1:REG_COUNT-1];
  logic [CNT_W-1:0] cnt_d [1:REG_COUNT-1];
  logic             overflow_q;
  logic             overflow_d;

  // Next counter values; a simultaneous increment and decrement of one register cancel out.
  always_comb begin
    overflow_d = overflow_q;
    for (int r = 1; r < REG_COUNT; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_en_i && (inc_addr_i == REG_ADDR_W'(r)) &&
          !(dec_en_i && (dec_addr_i == REG_ADDR_W'(r)))) begin
        if (cnt_q[r] == CNT_MAX) begin
          overflow_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + 1'b1;
        end
      end else if (dec_en_i && (dec_addr_i == REG_ADDR_W'(r)) &&
                   !(inc_en_i && (inc_addr_i == REG_ADDR_W'(r)))) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 1; r < REG_COUNT; r++) begin
        cnt_q[r] <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      overflow_q <= overflow_d;
    end
  end

  // Pending vector derived purely from registered counters.
  always_comb begin
    pending_o[0] = 1'b0;
    for (int r = 1; r < REG_COUNT; r++) begin
      pending_o[r] = (cnt_q[r] != '0);
    end
  end

  assign overflow_o = overflow_q;

endmodule

// File: rtl/hazard_controller.sv
// Execute-stage hazard controller: RAW stall generation from a write scoreboard
// and a fixed-length front-end flush after a taken branch.
// Optional performance counters are enabled by defining ECAP5_DPROC_HAZARD_PERF_EN.
//
// Handshake: an instruction moves from decode into execute only when
// issue_valid_i & issue_ready_i are both high and the controller is neither
// stalling, flushing, nor killing the current cycle; only such issues are
// recorded in the scoreboard.
module hazard_controller
  import ecap5_dproc_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_ready_i,
  input  logic                  issue_reg_write_i,
  input  logic [REG_ADDR_W-1:0] issue_reg_addr_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr_i,
  input  logic                  dec_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr_i,
  input  logic                  dec_rs2_used_i,
  input  logic                  wb_write_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic                  branch_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  kill_o,
  output hazard_state_t         dbg_state_o,
  output logic                  sb_overflow_o
`ifdef ECAP5_DPROC_HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles_o,
  output logic [31:0]           perf_flush_cycles_o
`endif
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

  hazard_state_t        state_q, state_d;
  logic [2:0]           flush_cnt_q, flush_cnt_d;
  logic [REG_COUNT-1:0] pending;
  logic                 issue;

  hazard_scoreboard #(
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_en_i   (issue & issue_reg_write_i),
    .inc_addr_i (issue_reg_addr_i),
    .dec_en_i   (wb_write_i),
    .dec_addr_i (wb_addr_i),
    .pending_o  (pending),
    .overflow_o (sb_overflow_o)
  );

  // No bypass: the stall depends only on registered counters.
  assign stall_o = (dec_rs1_used_i & pending[dec_rs1_addr_i]) |
                   (dec_rs2_used_i & pending[dec_rs2_addr_i]);
  assign kill_o  = branch_i;
  assign flush_o = (state_q == HAZARD_FLUSH);
  assign issue   = issue_valid_i & issue_ready_i & ~stall_o & ~flush_o & ~branch_i;
  assign dbg_state_o = state_q;

  // Flush sequencer: a branch (re)loads the drain count; count 0 returns to idle.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      HAZARD_IDLE: begin
        if (branch_i) begin
          state_d     = HAZARD_FLUSH;
          flush_cnt_d = FLUSH_RELOAD;
        end
      end
      HAZARD_FLUSH: begin
        if (branch_i) begin
          flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q == 3'd0) begin
          state_d = HAZARD_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d     = HAZARD_IDLE;
        flush_cnt_d = 3'd0;
      end
    endcase
  end

  // Flush sequencer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HAZARD_IDLE;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef ECAP5_DPROC_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating cycle counters for effective stalls and flush cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_o && issue_valid_i && !flush_o && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (flush_o && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_flush_cycles_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// random traffic, all compared against a behavioural model of the rules.
module tb_hazard_controller;
  import ecap5_dproc_pkg::*;

  localparam int FLUSH_DEPTH = 2;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       issue_valid, issue_ready, issue_reg_write;
  logic [4:0] issue_reg_addr, rs1_addr, rs2_addr, wb_addr;
  logic       rs1_used, rs2_used, wb_write, branch;
  logic       stall, flush, kill, sb_overflow;
  hazard_state_t dbg_state;
`ifdef ECAP5_DPROC_HAZARD_PERF_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  hazard_controller #(
    .FLUSH_DEPTH (FLUSH_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_ready_i     (issue_ready),
    .issue_reg_write_i (issue_reg_write),
    .issue_reg_addr_i  (issue_reg_addr),
    .dec_rs1_addr_i    (rs1_addr),
    .dec_rs1_used_i    (rs1_used),
    .dec_rs2_addr_i    (rs2_addr),
    .dec_rs2_used_i    (rs2_used),
    .wb_write_i        (wb_write),
    .wb_addr_i         (wb_addr),
    .branch_i          (branch),
    .stall_o           (stall),
    .flush_o           (flush),
    .kill_o            (kill),
    .dbg_state_o       (dbg_state),
    .sb_overflow_o     (sb_overflow)
`ifdef ECAP5_DPROC_HAZARD_PERF_EN
    ,
    .perf_stall_cycles_o (perf_stall),
    .perf_flush_cycles_o (perf_flush)
`endif
  );

  // Reference model state
  int          pend_m [32];
  bit          ovf_m;
  int          flush_left_m;
  longint      perf_stall_m, perf_flush_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 0;
    ovf_m = 0;
    flush_left_m = 0;
    perf_stall_m = 0;
    perf_flush_m = 0;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_ready = 1; issue_reg_write = 0; issue_reg_addr = 0;
    rs1_addr = 0; rs1_used = 0; rs2_addr = 0; rs2_used = 0;
    wb_write = 0; wb_addr = 0; branch = 0;
  endtask

  // Check outputs for the current inputs, then advance the model and clock one cycle.
  task automatic tick(input string tag);
    bit exp_stall, exp_flush, iss;
    int inc_r, dec_r;
    #3;
    exp_flush = (flush_left_m > 0);
    exp_stall = (rs1_used && pend_m[rs1_addr] > 0) || (rs2_used && pend_m[rs2_addr] > 0);
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, ".flush"}, 32'(flush), 32'(exp_flush));
    chk({tag, ".kill"}, 32'(kill), 32'(branch));
    chk({tag, ".ovf"}, 32'(sb_overflow), 32'(ovf_m));
    chk({tag, ".state"}, 32'(dbg_state), exp_flush ? 32'(HAZARD_FLUSH) : 32'(HAZARD_IDLE));
`ifdef ECAP5_DPROC_HAZARD_PERF_EN
    chk({tag, ".perf_stall"}, perf_stall, 32'(perf_stall_m));
    chk({tag, ".perf_flush"}, perf_flush, 32'(perf_flush_m));
`endif
    iss   = issue_valid && issue_ready && !exp_stall && !exp_flush && !branch;
    inc_r = (iss && issue_reg_write && issue_reg_addr != 0) ? int'(issue_reg_addr) : -1;
    dec_r = (wb_write && wb_addr != 0) ? int'(wb_addr) : -1;
    if (!(inc_r >= 0 && inc_r == dec_r)) begin
      if (inc_r >= 0) begin
        if (pend_m[inc_r] == CNT_MAX) ovf_m = 1;
        else pend_m[inc_r]++;
      end
      if (dec_r >= 0 && pend_m[dec_r] > 0) pend_m[dec_r]--;
    end
    if (exp_stall && issue_valid && !exp_flush && perf_stall_m < 64'hFFFF_FFFF) perf_stall_m++;
    if (exp_flush && perf_flush_m < 64'hFFFF_FFFF) perf_flush_m++;
    if (branch) flush_left_m = FLUSH_DEPTH;
    else if (flush_left_m > 0) flush_left_m--;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();

    // Reset held: outputs quiet
    rst = 1;
    @(posedge clk); #1;
    rs1_used = 1; rs1_addr = 5'd5;
    #2;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.ovf", 32'(sb_overflow), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    tick("idle0");

    // RAW on x5: stall until the cycle after its write-back
    issue_valid = 1; issue_reg_write = 1; issue_reg_addr = 5'd5;
    tick("raw.issue");
    issue_valid = 0; issue_reg_write = 0; rs1_used = 1; rs1_addr = 5'd5;
    tick("raw.stall0");
    tick("raw.stall1");
    wb_write = 1; wb_addr = 5'd5;
    tick("raw.wb");
    wb_write = 0;
    tick("raw.release");
    chk("raw.pend5", 32'(pend_m[5]), 32'd0);
    idle_inputs();

    // x0 is never pending
    issue_valid = 1; issue_reg_write = 1; issue_reg_addr = 5'd0;
    tick("x0.issue");
    idle_inputs(); rs1_used = 1; rs2_used = 1;
    tick("x0.read");
    tick("x0.read2");
    idle_inputs();

    // Single branch with a wrong-path x7 issue in the branch cycle
    tick("br.pre");
    branch = 1; issue_valid = 1; issue_reg_write = 1; issue_reg_addr = 5'd7;
    tick("br.kill");
    idle_inputs(); rs1_used = 1; rs1_addr = 5'd7;
    tick("br.f1");
    tick("br.f2");
    tick("br.done");
    idle_inputs();

    // Back-to-back branches extend the flush
    branch = 1;
    tick("br2.a");
    tick("br2.b");
    branch = 0;
    tick("br2.f2");
    tick("br2.f3");
    tick("br2.done");

    // Saturation on x3, then three write-backs clear it
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_reg_write = 1; issue_reg_addr = 5'd3;
      tick($sformatf("sat.issue%0d", i));
    end
    chk("sat.ovf_model", 32'(ovf_m), 32'd1);
    idle_inputs(); rs2_used = 1; rs2_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      wb_write = 1; wb_addr = 5'd3;
      tick($sformatf("sat.wb%0d", i));
    end
    wb_write = 0;
    tick("sat.clear");
    idle_inputs();

    // Asynchronous reset mid-flush with x4 pending
    issue_valid = 1; issue_reg_write = 1; issue_reg_addr = 5'd4;
    tick("ar.issue");
    idle_inputs(); branch = 1;
    tick("ar.branch");
    branch = 0; rs1_used = 1; rs1_addr = 5'd4;
    #1;
    rst = 1;
    #1;
    chk("ar.flush", 32'(flush), 32'd0);
    chk("ar.stall", 32'(stall), 32'd0);
    chk("ar.ovf", 32'(sb_overflow), 32'd0);
`ifdef ECAP5_DPROC_HAZARD_PERF_EN
    chk("ar.perf_stall", perf_stall, 32'd0);
    chk("ar.perf_flush", perf_flush, 32'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    tick("ar.after");
    idle_inputs();

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      issue_valid     = ($urandom_range(0, 3) != 0);
      issue_ready     = ($urandom_range(0, 4) != 0);
      issue_reg_write = ($urandom_range(0, 3) != 0);
      issue_reg_addr  = 5'($urandom_range(0, 7));
      rs1_used        = $urandom_range(0, 1) == 1;
      rs1_addr        = 5'($urandom_range(0, 7));
      rs2_used        = $urandom_range(0, 1) == 1;
      rs2_addr        = 5'($urandom_range(0, 7));
      wb_write        = ($urandom_range(0, 2) != 0);
      wb_addr         = 5'($urandom_range(0, 7));
      branch          = ($urandom_range(0, 15) == 0);
      tick($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
